// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Stall/flush sequencer for the 5-stage pipeline. Drives enable/clear of
//   IF/ID, ID/EX, EX/MEM, MEM/WB and the PC enable/redirect select.
//   Handles load-use bubbles, EX-resolved redirects and multi-cycle data
//   memory freezes guarded by a watchdog (WAIT_TIMEOUT).
//   Optional feature macro: PIPE_PERF_CNT_EN adds stall_cycles/flush_count.
module pipeline_hazard_ctrl #(
    parameter int WAIT_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_do_read_ctrl_ex,
    input  logic [4:0]  wr_reg_idx_ex,
    input  logic [4:0]  r1_reg_idx_id,
    input  logic [4:0]  r2_reg_idx_id,
    input  logic        branch_taken_ex,
    input  logic        do_jump_ex,
    input  logic        dmem_req_mem,
    input  logic        dmem_ready_mem,
    output logic        pc_enable,
    output logic        pc_redirect,
    output logic        if_id_enable,
    output logic        if_id_clear,
    output logic        id_ex_enable,
    output logic        id_ex_clear,
    output logic        ex_mem_enable,
    output logic        ex_mem_clear,
    output logic        mem_wb_enable,
    output logic        mem_wb_clear,
`ifdef PIPE_PERF_CNT_EN
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count,
`endif
    output logic        mem_timeout
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, TIMEOUT} state_t;

    localparam logic [15:0] WAIT_LIMIT = 16'(WAIT_TIMEOUT);

    state_t      state, state_nxt;
    logic [15:0] wait_cnt, wait_cnt_nxt;
    logic        timeout_nxt;

    logic mem_busy, redirect, load_use;

    assign mem_busy = dmem_req_mem & ~dmem_ready_mem;
    assign redirect = branch_taken_ex | do_jump_ex;
    assign load_use = mem_do_read_ctrl_ex & (wr_reg_idx_ex != 5'd0) &
                      ((wr_reg_idx_ex == r1_reg_idx_id) |
                       (wr_reg_idx_ex == r2_reg_idx_id));

    // Next-state and watchdog counter; TIMEOUT is only left through rst.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        timeout_nxt  = mem_timeout;
        case (state)
            RUN: begin
                if (mem_busy) begin
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = 16'd1;
                end
            end
            MEM_WAIT: begin
                if (!mem_busy) begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = 16'd0;
                end else if (wait_cnt == WAIT_LIMIT) begin
                    state_nxt   = TIMEOUT;
                    timeout_nxt = 1'b1;
                end else if (wait_cnt != 16'hFFFF) begin
                    wait_cnt_nxt = wait_cnt + 16'd1;
                end
            end
            default: state_nxt = TIMEOUT;
        endcase
    end

    // State, wait counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            wait_cnt    <= 16'd0;
            mem_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_cnt_nxt;
            mem_timeout <= timeout_nxt;
        end
    end

    // Pipeline control outputs, highest priority condition first.
    always_comb begin
        pc_enable     = 1'b1;
        pc_redirect   = 1'b0;
        if_id_enable  = 1'b1;
        if_id_clear   = 1'b0;
        id_ex_enable  = 1'b1;
        id_ex_clear   = 1'b0;
        ex_mem_enable = 1'b1;
        ex_mem_clear  = 1'b0;
        mem_wb_enable = 1'b1;
        mem_wb_clear  = 1'b0;
        if (rst) begin
            pc_enable     = 1'b0;
            if_id_enable  = 1'b0;
            if_id_clear   = 1'b1;
            id_ex_enable  = 1'b0;
            id_ex_clear   = 1'b1;
            ex_mem_enable = 1'b0;
            ex_mem_clear  = 1'b1;
            mem_wb_enable = 1'b0;
            mem_wb_clear  = 1'b1;
        end else if (state == TIMEOUT) begin
            pc_enable     = 1'b0;
            if_id_enable  = 1'b0;
            id_ex_enable  = 1'b0;
            ex_mem_enable = 1'b0;
            mem_wb_enable = 1'b0;
        end else if (mem_busy) begin
            // Freeze everything up to MEM; WB receives a bubble. Any pending
            // redirect/load-use stays in place and acts once MEM completes.
            pc_enable     = 1'b0;
            if_id_enable  = 1'b0;
            id_ex_enable  = 1'b0;
            ex_mem_enable = 1'b0;
            mem_wb_clear  = 1'b1;
        end else if (redirect) begin
            // Squash the two younger instructions; ID is dead so load-use is moot.
            pc_redirect = 1'b1;
            if_id_clear = 1'b1;
            id_ex_clear = 1'b1;
        end else if (load_use) begin
            pc_enable    = 1'b0;
            if_id_enable = 1'b0;
            id_ex_clear  = 1'b1;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    // Performance counters: stalled-PC cycles (excluding rst/TIMEOUT) and redirects.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= 32'd0;
            flush_count  <= 32'd0;
        end else begin
            if (!pc_enable && state != TIMEOUT)
                stall_cycles <= stall_cycles + 32'd1;
            if (pc_redirect)
                flush_count <= flush_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (WAIT_TIMEOUT=4).
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld;
    logic [4:0]  wr, r1, r2;
    logic        br, jmp, req, rdy;
    logic        pc_enable, pc_redirect;
    logic        if_id_enable, if_id_clear, id_ex_enable, id_ex_clear;
    logic        ex_mem_enable, ex_mem_clear, mem_wb_enable, mem_wb_clear;
    logic        mem_timeout;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_count;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.WAIT_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .mem_do_read_ctrl_ex(ld), .wr_reg_idx_ex(wr),
        .r1_reg_idx_id(r1), .r2_reg_idx_id(r2),
        .branch_taken_ex(br), .do_jump_ex(jmp),
        .dmem_req_mem(req), .dmem_ready_mem(rdy),
        .pc_enable(pc_enable), .pc_redirect(pc_redirect),
        .if_id_enable(if_id_enable), .if_id_clear(if_id_clear),
        .id_ex_enable(id_ex_enable), .id_ex_clear(id_ex_clear),
        .ex_mem_enable(ex_mem_enable), .ex_mem_clear(ex_mem_clear),
        .mem_wb_enable(mem_wb_enable), .mem_wb_clear(mem_wb_clear),
`ifdef PIPE_PERF_CNT_EN
        .stall_cycles(stall_cycles), .flush_count(flush_count),
`endif
        .mem_timeout(mem_timeout)
    );

    // {pc_en, redir, ifid_en, ifid_clr, idex_en, idex_clr, exm_en, exm_clr, mwb_en, mwb_clr, timeout}
    localparam logic [10:0] O_RST   = 11'b0_0_01_01_01_01_0;
    localparam logic [10:0] O_NORM  = 11'b1_0_10_10_10_10_0;
    localparam logic [10:0] O_REDIR = 11'b1_1_11_11_10_10_0;
    localparam logic [10:0] O_LU    = 11'b0_0_00_11_10_10_0;
    localparam logic [10:0] O_BUSY  = 11'b0_0_00_00_00_11_0;
    localparam logic [10:0] O_TOUT  = 11'b0_0_00_00_00_00_1;

    typedef struct {
        logic        rst, ld;
        logic [4:0]  wr, r1, r2;
        logic        br, jmp, req, rdy;
        logic [10:0] exp;
        string       name;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic l, logic [4:0] w, logic [4:0] a,
                                logic [4:0] b, logic bt, logic j, logic q,
                                logic y, logic [10:0] e, string n);
        vec_t v;
        v.rst = r; v.ld = l; v.wr = w; v.r1 = a; v.r2 = b;
        v.br = bt; v.jmp = j; v.req = q; v.rdy = y; v.exp = e; v.name = n;
        return v;
    endfunction

    function automatic logic [10:0] outs();
        return {pc_enable, pc_redirect, if_id_enable, if_id_clear,
                id_ex_enable, id_ex_clear, ex_mem_enable, ex_mem_clear,
                mem_wb_enable, mem_wb_clear, mem_timeout};
    endfunction

    task automatic drv(input logic r, input logic l, input logic [4:0] w,
                       input logic [4:0] a, input logic [4:0] b, input logic bt,
                       input logic j, input logic q, input logic y);
        @(posedge clk);
        #1;
        rst = r; ld = l; wr = w; r1 = a; r2 = b; br = bt; jmp = j; req = q; rdy = y;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    initial begin
        int n;
        rst = 1'b1; ld = 0; wr = 0; r1 = 0; r2 = 0; br = 0; jmp = 0; req = 0; rdy = 0;

        //            rst ld wr  r1  r2 br jmp req rdy expected
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, O_RST,   "reset"));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_NORM,  "idle"));
        tbl.push_back(mk(0, 1, 5, 5, 0, 0, 0, 0, 0, O_LU,    "lu_r1"));
        tbl.push_back(mk(0, 0, 0, 5, 0, 0, 0, 0, 0, O_NORM,  "lu_bubble_ex"));
        tbl.push_back(mk(0, 1, 7, 1, 7, 0, 0, 0, 0, O_LU,    "lu_r2"));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, O_NORM,  "lu_x0"));
        tbl.push_back(mk(0, 1, 5, 6, 7, 0, 0, 0, 0, O_NORM,  "lu_nomatch"));
        tbl.push_back(mk(0, 0, 5, 5, 0, 0, 0, 0, 0, O_NORM,  "no_load"));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, O_REDIR, "branch"));
        tbl.push_back(mk(0, 1, 3, 3, 0, 0, 1, 0, 0, O_REDIR, "jump_over_lu"));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, O_NORM,  "mem_1cycle"));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, O_BUSY,  "busy1"));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, O_BUSY,  "busy2"));
        tbl.push_back(mk(0, 1, 4, 4, 0, 1, 0, 1, 0, O_BUSY,  "busy3_redir_held"));
        tbl.push_back(mk(0, 1, 4, 4, 0, 1, 0, 1, 1, O_REDIR, "ready_redir"));
        tbl.push_back(mk(0, 1, 4, 4, 0, 0, 0, 0, 0, O_LU,    "lu_after_mem"));
        // exactly WAIT_TIMEOUT busy cycles must not trip the watchdog
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, O_BUSY,  "b4_1"));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, O_BUSY,  "b4_2"));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, O_BUSY,  "b4_3"));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, O_BUSY,  "b4_4"));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, O_NORM,  "b4_ready"));
        // rst mid-wait must restart the watchdog count
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, O_BUSY,  "rw_1"));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, O_BUSY,  "rw_2"));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, O_RST,   "rw_rst"));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, O_BUSY,  "rw_3"));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, O_BUSY,  "rw_4"));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, O_BUSY,  "rw_5"));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, O_BUSY,  "rw_6"));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, O_NORM,  "rw_ready"));

        // one unchecked reset cycle to bring state out of X
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
        foreach (tbl[i]) begin
            drv(tbl[i].rst, tbl[i].ld, tbl[i].wr, tbl[i].r1, tbl[i].r2,
                tbl[i].br, tbl[i].jmp, tbl[i].req, tbl[i].rdy);
            @(negedge clk);
            chk(tbl[i].name, 32'(outs()), 32'(tbl[i].exp));
        end

        // Watchdog: ready held low, count edges until mem_timeout rises.
        drv(0, 0, 0, 0, 0, 0, 0, 1, 0);
        n = 0;
        while (!mem_timeout && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("timeout_edges", 32'(n), 32'd5);
        drv(0, 1, 2, 2, 0, 1, 0, 1, 1);
        @(negedge clk);
        chk("timeout_frozen", 32'(outs()), 32'(O_TOUT));
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("timeout_sticky", 32'(outs()), 32'(O_TOUT));
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("timeout_rst_cycle", 32'(outs()), 32'(O_RST | 11'b1));
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("after_timeout_rst", 32'(outs()), 32'(O_NORM));

`ifdef PIPE_PERF_CNT_EN
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
        drv(0, 1, 5, 5, 0, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        drv(0, 1, 6, 0, 6, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 1, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("perf_stall", stall_cycles, 32'd2);
        chk("perf_flush", flush_count, 32'd1);
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("perf_stall_rst", stall_cycles, 32'd0);
        chk("perf_flush_rst", flush_count, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
